// File: rtl/majority_voter_pipe_if.sv
// Bundle of the voter's data-in / vote-out signals.
// The master drives channel words and fault_clr; the slave (the voter)
// returns the voted word, per-channel disagreement, fault and statistics.
interface majority_voter_pipe_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    parameter int CNT_W = 8
);
    logic                   in_valid;
    logic [NCH*WIDTH-1:0]   in_data;
    logic                   fault_clr;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic [NCH-1:0]         disagree;
    logic [NCH-1:0]         fault;
    logic [NCH*CNT_W-1:0]   mismatch_cnt;

    modport master (
        output in_valid, in_data, fault_clr,
        input  out_valid, out_data, disagree, fault, mismatch_cnt
    );

    modport slave (
        input  in_valid, in_data, fault_clr,
        output out_valid, out_data, disagree, fault, mismatch_cnt
    );
endinterface

// File: rtl/majority_voter_pipe.sv
// Registered N-channel bitwise majority voter with per-channel fault tracking.
// Each valid cycle the NCH channel words are voted bit by bit; the result,
// the per-channel disagreement flags and the fault flags appear one cycle later.
// A channel that disagrees on THRESH consecutive valid samples becomes faulty
// and stays so until fault_clr or rst.
// Optional macro VOTER_STATS_EN adds saturating per-channel mismatch counters;
// without it the mismatch_cnt outputs are held at zero.
module majority_voter_pipe #(
    parameter int WIDTH  = 8,
    parameter int NCH    = 3,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    majority_voter_pipe_if.slave   bus
);

    generate
        if (NCH < 3 || NCH > 7 || (NCH % 2) == 0) begin : g_bad_nch
            $error("majority_voter_pipe: NCH must be odd and within 3..7");
        end
        if (THRESH < 1 || THRESH > 255) begin : g_bad_thresh
            $error("majority_voter_pipe: THRESH must be within 1..255");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("majority_voter_pipe: WIDTH must be at least 1");
        end
    endgenerate

    localparam logic [3:0] HALF     = 4'(NCH / 2);
    localparam logic [7:0] THRESH_V = 8'(THRESH);

    typedef enum logic [1:0] {
        ST_OK,
        ST_SUSPECT,
        ST_FAULT
    } ch_state_e;

    logic [WIDTH-1:0] vote;
    logic [NCH-1:0]   mismatch;
    logic [3:0]       ones_cnt;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [NCH-1:0]   disagree_q,  disagree_d;
    logic [NCH-1:0]   fault_q,     fault_d;

    ch_state_e        state_q [NCH];
    ch_state_e        state_d [NCH];
    logic [7:0]       run_q   [NCH];
    logic [7:0]       run_d   [NCH];

    // Bitwise majority of the incoming words and whole-word disagreement per channel
    always_comb begin
        vote     = '0;
        mismatch = '0;
        ones_cnt = '0;
        for (int b = 0; b < WIDTH; b++) begin
            ones_cnt = '0;
            for (int c = 0; c < NCH; c++) begin
                ones_cnt = ones_cnt + {3'b000, bus.in_data[c*WIDTH + b]};
            end
            vote[b] = (ones_cnt > HALF);
        end
        for (int c = 0; c < NCH; c++) begin
            mismatch[c] = (bus.in_data[c*WIDTH +: WIDTH] != vote);
        end
    end

    // Output stage: vote and disagreement are captured on valid samples and held otherwise
    always_comb begin
        out_valid_d = bus.in_valid;
        out_data_d  = out_data_q;
        disagree_d  = disagree_q;
        if (bus.in_valid) begin
            out_data_d = vote;
            disagree_d = mismatch;
        end
    end

    // Per-channel OK/SUSPECT/FAULT tracking; fault_clr wins over any sample in the same cycle
    always_comb begin
        fault_d = '0;
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            run_d[c]   = run_q[c];
            if (bus.fault_clr) begin
                state_d[c] = ST_OK;
                run_d[c]   = '0;
            end else if (bus.in_valid) begin
                case (state_q[c])
                    ST_OK: begin
                        if (mismatch[c]) begin
                            run_d[c]   = 8'd1;
                            state_d[c] = (THRESH == 1) ? ST_FAULT : ST_SUSPECT;
                        end
                    end
                    ST_SUSPECT: begin
                        if (mismatch[c]) begin
                            run_d[c] = run_q[c] + 8'd1;
                            if (run_d[c] == THRESH_V) begin
                                state_d[c] = ST_FAULT;
                            end
                        end else begin
                            run_d[c]   = '0;
                            state_d[c] = ST_OK;
                        end
                    end
                    ST_FAULT: begin
                    end
                    default: begin
                        state_d[c] = ST_OK;
                        run_d[c]   = '0;
                    end
                endcase
            end
            fault_d[c] = (state_d[c] == ST_FAULT);
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            disagree_q  <= '0;
            fault_q     <= '0;
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= ST_OK;
                run_q[c]   <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            disagree_q  <= disagree_d;
            fault_q     <= fault_d;
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                run_q[c]   <= run_d[c];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.disagree  = disagree_q;
    assign bus.fault     = fault_q;

`ifdef VOTER_STATS_EN
    logic [CNT_W-1:0]     cnt_q [NCH];
    logic [CNT_W-1:0]     cnt_d [NCH];
    logic [NCH*CNT_W-1:0] cnt_flat;

    // Saturating count of every valid disagreeing sample, cleared with the fault state
    always_comb begin
        cnt_flat = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (bus.fault_clr) begin
                cnt_d[c] = '0;
            end else if (bus.in_valid && mismatch[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
            cnt_flat[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign bus.mismatch_cnt = cnt_flat;
`else
    assign bus.mismatch_cnt = {(NCH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_majority_voter_pipe.sv
// Testbench for majority_voter_pipe (NCH=3, WIDTH=8, THRESH=4, CNT_W=8).
// A behavioural model tracks vote, consecutive-disagreement runs, sticky
// faults and saturating totals; a negedge process compares every cycle.
module tb_majority_voter_pipe;

    localparam int WIDTH  = 8;
    localparam int NCH    = 3;
    localparam int THRESH = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    majority_voter_pipe_if #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) bus ();

    majority_voter_pipe #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .THRESH(THRESH),
        .CNT_W (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic [NCH-1:0]   exp_dis;
    int               run_m   [NCH];
    bit               fault_m [NCH];
    int               cnt_m   [NCH];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*WIDTH-1:0] pack3(input logic [WIDTH-1:0] w0,
                                                   input logic [WIDTH-1:0] w1,
                                                   input logic [WIDTH-1:0] w2);
        return {w2, w1, w0};
    endfunction

    function automatic logic [WIDTH-1:0] modelVote(input logic [NCH*WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < WIDTH; b++) begin
            int ones;
            ones = 0;
            for (int c = 0; c < NCH; c++) ones += int'(d[c*WIDTH + b]);
            r[b] = (ones * 2 > NCH);
        end
        return r;
    endfunction

    function automatic logic [NCH-1:0] expFault();
        logic [NCH-1:0] f;
        for (int c = 0; c < NCH; c++) f[c] = fault_m[c];
        return f;
    endfunction

    function automatic logic [NCH*CNT_W-1:0] expCnt();
        logic [NCH*CNT_W-1:0] v;
        v = '0;
`ifdef VOTER_STATS_EN
        for (int c = 0; c < NCH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(cnt_m[c]);
`endif
        return v;
    endfunction

    task automatic modelReset();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_dis   = '0;
        for (int c = 0; c < NCH; c++) begin
            run_m[c] = 0; fault_m[c] = 1'b0; cnt_m[c] = 0;
        end
    endtask

    task automatic modelUpdate(input logic v, input logic [NCH*WIDTH-1:0] d, input logic clr);
        logic [WIDTH-1:0] vt;
        logic [NCH-1:0]   dis;
        vt  = modelVote(d);
        dis = '0;
        for (int c = 0; c < NCH; c++) dis[c] = (d[c*WIDTH +: WIDTH] != vt);
        exp_valid = v;
        if (v) begin
            exp_data = vt;
            exp_dis  = dis;
        end
        if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                run_m[c] = 0; fault_m[c] = 1'b0; cnt_m[c] = 0;
            end
        end else if (v) begin
            for (int c = 0; c < NCH; c++) begin
                if (dis[c]) begin
                    if (cnt_m[c] < CNT_MAX) cnt_m[c]++;
                    if (!fault_m[c]) begin
                        run_m[c]++;
                        if (run_m[c] >= THRESH) fault_m[c] = 1'b1;
                    end
                end else if (!fault_m[c]) begin
                    run_m[c] = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("out_valid",    64'(bus.out_valid),    64'(exp_valid));
        checkVal("out_data",     64'(bus.out_data),     64'(exp_data));
        checkVal("disagree",     64'(bus.disagree),     64'(exp_dis));
        checkVal("fault",        64'(bus.fault),        64'(expFault()));
        checkVal("mismatch_cnt", 64'(bus.mismatch_cnt), 64'(expCnt()));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at the next negedge
    task automatic applyStimulus(input logic v, input logic [NCH*WIDTH-1:0] d, input logic clr);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.fault_clr = clr;
        @(posedge clk);
        modelUpdate(v, d, clr);
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_valid"}, 64'(bus.out_valid),    64'd0);
        checkVal({tag, "_data"},  64'(bus.out_data),     64'd0);
        checkVal({tag, "_dis"},   64'(bus.disagree),     64'd0);
        checkVal({tag, "_fault"}, 64'(bus.fault),        64'd0);
        checkVal({tag, "_cnt"},   64'(bus.mismatch_cnt), 64'd0);
    endtask

    task automatic doReset();
        check_en      = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        modelReset();
        rst      = 1'b0;
        check_en = 1'b1;
    endtask

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (check_en && !rst) checkOutput();
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [NCH*WIDTH-1:0] bad2;
        logic [NCH*WIDTH-1:0] good;
        int prob [NCH];
        doReset();

        // T1: two agreeing channels outvote the third
        applyStimulus(1'b1, pack3(8'h5A, 8'h5A, 8'hFF), 1'b0);
        checkVal("t1_valid", 64'(bus.out_valid), 64'd1);
        checkVal("t1_data",  64'(bus.out_data),  64'h5A);
        checkVal("t1_dis",   64'(bus.disagree),  64'b100);
        checkVal("t1_model", 64'(exp_data),      64'h5A);

        // T2: bitwise vote across three different words
        applyStimulus(1'b1, pack3(8'hF0, 8'h3C, 8'h0F), 1'b0);
        checkVal("t2_data",  64'(bus.out_data), 64'h3C);
        checkVal("t2_dis",   64'(bus.disagree), 64'b101);
        checkVal("t2_model", 64'(exp_dis),      64'b101);

        // Idle cycle holds data, drops valid; then clear run state
        applyStimulus(1'b0, pack3(8'h00, 8'h11, 8'h22), 1'b0);
        checkVal("hold_valid", 64'(bus.out_valid), 64'd0);
        checkVal("hold_data",  64'(bus.out_data),  64'h3C);
        applyStimulus(1'b0, '0, 1'b1);

        // T3: four ch2 disagreements separated by idle gaps
        bad2 = pack3(8'h11, 8'h11, 8'h22);
        good = pack3(8'h11, 8'h11, 8'h11);
        for (int k = 0; k < THRESH; k++) begin
            applyStimulus(1'b1, bad2, 1'b0);
            checkVal("t3_fault", 64'(bus.fault), (k == THRESH - 1) ? 64'b100 : 64'd0);
            applyStimulus(1'b0, good, 1'b0);
            applyStimulus(1'b0, good, 1'b0);
        end
        checkVal("t3_sticky", 64'(bus.fault), 64'b100);
        applyStimulus(1'b1, good, 1'b0);
        checkVal("t3_sticky2", 64'(bus.fault), 64'b100);

        // T5: fault_clr with a disagreeing sample, then re-fault after four more
        applyStimulus(1'b1, bad2, 1'b1);
        checkVal("t5_fault", 64'(bus.fault),    64'd0);
        checkVal("t5_dis",   64'(bus.disagree), 64'b100);
        for (int k = 0; k < THRESH; k++) begin
            applyStimulus(1'b1, bad2, 1'b0);
            checkVal("t5_refault", 64'(bus.fault), (k == THRESH - 1) ? 64'b100 : 64'd0);
        end

        // T4: three disagreements, one agreement, three more -> no fault
        applyStimulus(1'b0, good, 1'b1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, (k == 3) ? good : bad2, 1'b0);
        end
        checkVal("t4_fault", 64'(bus.fault), 64'd0);
        checkVal("t4_model", 64'(expFault()), 64'd0);

        // Randomized traffic with biased corruption and occasional clears
        prob[0] = 10; prob[1] = 55; prob[2] = 30;
        for (int n = 0; n < 500; n++) begin
            logic [WIDTH-1:0]     base;
            logic [NCH*WIDTH-1:0] d;
            base = WIDTH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 99) < prob[c])
                    d[c*WIDTH +: WIDTH] = base ^ WIDTH'($urandom_range(1, 255));
                else
                    d[c*WIDTH +: WIDTH] = base;
            end
            applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 59) == 0);
        end

        // T6: 300 ch1 disagreements saturate its counter when stats are built in
        applyStimulus(1'b0, good, 1'b1);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b1, pack3(8'hAA, 8'h55, 8'hAA), 1'b0);
        end
`ifdef VOTER_STATS_EN
        checkVal("t6_cnt_ch1", 64'(bus.mismatch_cnt[CNT_W +: CNT_W]), 64'd255);
`else
        checkVal("t6_cnt_ch1", 64'(bus.mismatch_cnt[CNT_W +: CNT_W]), 64'd0);
`endif
        checkVal("t6_fault", 64'(bus.fault), 64'b010);

        // Mid-cycle reset clears every output before the next edge
        bus.in_valid = 1'b1;
        bus.in_data  = pack3(8'hAA, 8'h55, 8'hAA);
        #2;
        check_en = 1'b0;
        rst      = 1'b1;
        #1;
        checkAllZero("midrst");
        @(negedge clk);
        modelReset();
        bus.in_valid = 1'b0;
        rst      = 1'b0;
        check_en = 1'b1;
        applyStimulus(1'b1, pack3(8'h01, 8'h01, 8'h03), 1'b0);
        checkVal("post_rst_data", 64'(bus.out_data), 64'h01);
        applyStimulus(1'b0, good, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
